// File: rtl/fsign_pkg.sv
// =============================================================================
// Module      : fsign_pkg
// Description : Op encodings and sign-injection helper for fsign_arbiter.
// Revision    : 1.0
// =============================================================================
`default_nettype none

package fsign_pkg;

  localparam int c_XLEN = 32;

  typedef enum logic [2:0] {
    FSGNJ  = 3'b000,
    FSGNJN = 3'b001,
    FSGNJX = 3'b010,
    FABS   = 3'b011,
    FNEG   = 3'b100
  } fsign_op_t;

  // Returns {illegal, result}; illegal encodings yield a zero result.
  function automatic logic [c_XLEN:0] fsign_compute(
    input logic [2:0]        op,
    input logic [c_XLEN-1:0] x1,
    input logic [c_XLEN-1:0] x2
  );
    logic [c_XLEN:0] r;
    case (op)
      FSGNJ:   r = {1'b0, x2[31], x1[30:0]};
      FSGNJN:  r = {1'b0, ~x2[31], x1[30:0]};
      FSGNJX:  r = {1'b0, x1[31] ^ x2[31], x1[30:0]};
      FABS:    r = {1'b0, 1'b0, x1[30:0]};
      FNEG:    r = {1'b0, ~x1[31], x1[30:0]};
      default: r = {1'b1, {c_XLEN{1'b0}}};
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fsign_rr_arb.sv
// =============================================================================
// Module      : fsign_rr_arb
// Description : Round-robin arbiter; pointer moves past the winner on advance.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module fsign_rr_arb #(
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          valid_i,
  input  logic                     en_i,
  input  logic                     adv_i,
  output logic [NREQ-1:0]          grant_o,
  output logic [$clog2(NREQ)-1:0]  idx_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] w_idx;
  logic          w_found;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && valid_i[wrap_add(ptr_q, k)]) begin
        w_found = 1'b1;
        w_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_o[i] = en_i && w_found && (w_idx == IW'(i));
    end
  end

  assign idx_o = w_idx;
  assign ptr_d = adv_i ? wrap_add(w_idx, 1) : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fsign_arbiter.sv
// =============================================================================
// Module      : fsign_arbiter
// Description : N-way shared FP sign-injection unit with in-order result FIFO.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module fsign_arbiter
  import fsign_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int TAGW  = 5,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*3-1:0]        req_op,
  input  logic [NREQ*32-1:0]       req_x1,
  input  logic [NREQ*32-1:0]       req_x2,
  input  logic [NREQ*TAGW-1:0]     req_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [TAGW-1:0]          out_tag,
  output logic [$clog2(NREQ)-1:0]  out_src,
  output logic                     out_illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(NREQ);
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

  logic [NREQ-1:0]   w_gnt;
  logic [SW-1:0]     w_gnt_idx;
  logic              w_can_push;
  logic              w_push;
  logic              w_pop;
  logic [2:0]        w_sel_op;
  logic [31:0]       w_sel_x1;
  logic [31:0]       w_sel_x2;
  logic [TAGW-1:0]   w_sel_tag;
  logic [32:0]       w_sel_res;

  logic [31:0]       data_q [DEPTH];
  logic [TAGW-1:0]   tag_q  [DEPTH];
  logic [SW-1:0]     src_q  [DEPTH];
  logic              ill_q  [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Fullness is judged on the registered count only, so a same-cycle pop
  // never opens a slot and req_ready stays independent of out_ready.
  assign w_can_push = !rst && (count_q < c_FULL);

  fsign_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i (req_valid),
    .en_i    (w_can_push),
    .adv_i   (w_push),
    .grant_o (w_gnt),
    .idx_o   (w_gnt_idx)
  );

  assign req_ready = w_gnt;
  assign w_push    = |w_gnt;
  assign w_pop     = !rst && (count_q != '0) && out_ready;

  assign w_sel_op  = req_op [w_gnt_idx*3    +: 3];
  assign w_sel_x1  = req_x1 [w_gnt_idx*32   +: 32];
  assign w_sel_x2  = req_x2 [w_gnt_idx*32   +: 32];
  assign w_sel_tag = req_tag[w_gnt_idx*TAGW +: TAGW];
  assign w_sel_res = fsign_compute(w_sel_op, w_sel_x1, w_sel_x2);

  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(w_push) - CW'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
        src_q[i]  <= '0;
        ill_q[i]  <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (w_push) begin
        data_q[wr_ptr_q] <= w_sel_res[31:0];
        tag_q[wr_ptr_q]  <= w_sel_tag;
        src_q[wr_ptr_q]  <= w_gnt_idx;
        ill_q[wr_ptr_q]  <= w_sel_res[32];
      end
    end
  end

  // Outputs are forced quiet while rst is high so nothing stale leaks out.
  assign out_valid   = !rst && (count_q != '0);
  assign out_data    = rst ? '0   : data_q[rd_ptr_q];
  assign out_tag     = rst ? '0   : tag_q[rd_ptr_q];
  assign out_src     = rst ? '0   : src_q[rd_ptr_q];
  assign out_illegal = rst ? 1'b0 : ill_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: tb/tb_fsign_arbiter.sv
// =============================================================================
// Module      : tb_fsign_arbiter
// Description : Directed self-checking bench for fsign_arbiter (NREQ=2, DEPTH=2).
// Revision    : 1.0
// =============================================================================
`default_nettype none

module tb_fsign_arbiter;

  localparam int NREQ  = 2;
  localparam int TAGW  = 5;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2:0]        op0, op1;
  logic [31:0]       x1_0, x1_1, x2_0, x2_1;
  logic [TAGW-1:0]   tag0, tag1;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [TAGW-1:0]   out_tag;
  logic [0:0]        out_src;
  logic              out_illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsign_arbiter #(
    .NREQ  (NREQ),
    .TAGW  (TAGW),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      ({op1, op0}),
    .req_x1      ({x1_1, x1_0}),
    .req_x2      ({x2_1, x2_0}),
    .req_tag     ({tag1, tag0}),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .out_src     (out_src),
    .out_illegal (out_illegal)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [31:0] d,
                         input logic [TAGW-1:0] t, input logic s, input logic il);
    chk({name, ".valid"}, 64'(out_valid), 64'(v));
    chk({name, ".data"},  64'(out_data),  64'(d));
    chk({name, ".tag"},   64'(out_tag),   64'(t));
    chk({name, ".src"},   64'(out_src),   64'(s));
    chk({name, ".ill"},   64'(out_illegal), 64'(il));
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b11; out_ready = 1'b1;
    op0 = 3'b000; op1 = 3'b000; x1_0 = '0; x1_1 = '0; x2_0 = '0; x2_1 = '0;
    tag0 = '0; tag1 = '0;
    tick();
    tick();
    chk("reset.ready", 64'(req_ready), 64'(2'b00));
    chk_out("reset", 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0; req_valid = 2'b00;
    #1;
    chk_out("post_reset", 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);

    // Single FSGNJX from req0
    op0 = 3'b010; x1_0 = 32'h3F80_0000; x2_0 = 32'hC000_0000; tag0 = 5'd3;
    req_valid = 2'b01;
    #1 chk("single.ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    #1 chk_out("single", 1'b1, 32'hBF80_0000, 5'd3, 1'b0, 1'b0);
    tick();
    chk("single.drained", 64'(out_valid), 64'(1'b0));

    // Illegal op from req1; pointer is at 1 and moves to 0
    op1 = 3'b110; x1_1 = 32'hFFFF_FFFF; x2_1 = 32'h1234_5678; tag1 = 5'd7;
    req_valid = 2'b10;
    #1 chk("illegal.ready", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid = 2'b00;
    #1 chk_out("illegal", 1'b1, 32'h0, 5'd7, 1'b1, 1'b1);
    tick();

    // Round robin: both requesters valid from P=0
    op0 = 3'b100; x1_0 = 32'h4049_0FDB; x2_0 = 32'hFFFF_FFFF; tag0 = 5'd1;
    op1 = 3'b011; x1_1 = 32'hC049_0FDB; x2_1 = 32'h0000_0000; tag1 = 5'd2;
    req_valid = 2'b11;
    #1 chk("rr.ready0", 64'(req_ready), 64'(2'b01));
    tick();
    for (int n = 1; n <= 4; n++) begin
      chk("rr.ready", 64'(req_ready), (n % 2 == 1) ? 64'(2'b10) : 64'(2'b01));
      chk_out("rr", 1'b1, (n % 2 == 1) ? 32'hC049_0FDB : 32'h4049_0FDB,
              (n % 2 == 1) ? 5'd1 : 5'd2, (n % 2 == 1) ? 1'b0 : 1'b1, 1'b0);
      tick();
    end
    req_valid = 2'b00;
    #1 chk_out("rr.last", 1'b1, 32'hC049_0FDB, 5'd1, 1'b0, 1'b0);
    tick();
    chk("rr.drained", 64'(out_valid), 64'(1'b0));

    // Backpressure: req0 streams FSGNJ with out_ready low
    out_ready = 1'b0;
    op0 = 3'b000; x2_0 = 32'h8000_0000;
    x1_0 = 32'h10; tag0 = 5'd10; req_valid = 2'b01;
    #1 chk("bp.ready0", 64'(req_ready), 64'(2'b01));
    tick();
    x1_0 = 32'h11; tag0 = 5'd11;
    #1 chk("bp.ready1", 64'(req_ready), 64'(2'b01));
    tick();
    x1_0 = 32'h12; tag0 = 5'd12;
    #1 chk("bp.full_ready", 64'(req_ready), 64'(2'b00));
    chk_out("bp.head0", 1'b1, 32'h8000_0010, 5'd10, 1'b0, 1'b0);
    tick();
    chk("bp.still_full", 64'(req_ready), 64'(2'b00));
    out_ready = 1'b1;
    #1 chk("bp.full_pop_ready", 64'(req_ready), 64'(2'b00));
    tick();
    chk_out("bp.head1", 1'b1, 32'h8000_0011, 5'd11, 1'b0, 1'b0);
    chk("bp.reopen", 64'(req_ready), 64'(2'b01));
    tick();
    x1_0 = 32'h13; tag0 = 5'd13;
    #1 chk_out("bp.head2", 1'b1, 32'h8000_0012, 5'd12, 1'b0, 1'b0);
    chk("bp.steady", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    #1 chk_out("bp.head3", 1'b1, 32'h8000_0013, 5'd13, 1'b0, 1'b0);
    tick();
    chk("bp.drained", 64'(out_valid), 64'(1'b0));
    tick();
    chk("bp.empty_pop", 64'(out_valid), 64'(1'b0));

    // Reset mid-operation with two entries queued from req0 (P -> 1)
    out_ready = 1'b0;
    op0 = 3'b001; x1_0 = 32'h1234_5678; x2_0 = 32'h0; tag0 = 5'd5;
    req_valid = 2'b01;
    tick();
    tick();
    req_valid = 2'b00;
    #1 chk("mid.full_valid", 64'(out_valid), 64'(1'b1));
    rst = 1'b1; req_valid = 2'b11;
    #1 chk("mid.rst_ready", 64'(req_ready), 64'(2'b00));
    chk_out("mid.rst", 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0; req_valid = 2'b00; out_ready = 1'b1;
    #1 chk_out("mid.after", 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("mid.no_stale", 64'(out_valid), 64'(1'b0));
    req_valid = 2'b11;
    #1 chk("mid.ptr_reset", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    #1 chk_out("mid.fsgnjn", 1'b1, 32'h9234_5678, 5'd5, 1'b0, 1'b0);
    tick();
    chk("mid.drained", 64'(out_valid), 64'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
